// File: rtl/inst_buffer_if.sv
// Fetch/decode side bundle of the instruction buffer.
// master drives fetch inputs and decode ready; slave is the buffer.
interface inst_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [INST_W-1:0] in_inst;
    logic              in_branch;
    logic [ADDR_W-1:0] in_branch_addr;
    logic              fetch_stall;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_branch;
    logic [ADDR_W-1:0] out_branch_addr;
    logic              out_adef;
    logic [CW-1:0]     count;

    modport master (
        output in_valid, in_pc, in_inst, in_branch, in_branch_addr,
        output out_ready,
        input  in_ready, fetch_stall, out_valid, out_pc, out_inst,
        input  out_branch, out_branch_addr, out_adef, count
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_branch, in_branch_addr,
        input  out_ready,
        output in_ready, fetch_stall, out_valid, out_pc, out_inst,
        output out_branch, out_branch_addr, out_adef, count
    );
endinterface

// File: rtl/inst_buffer.sv
// Circular FIFO between fetch and decode with stall and flush.
// INST_BUF_BYPASS_EN: empty buffer forwards fetch entry in same cycle.
module inst_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    inst_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              branch;
        logic [ADDR_W-1:0] baddr;
        logic              adef;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic   w_empty;
    logic   w_in_ready;
    logic   w_push;
    logic   w_wr;
    logic   w_rd;
    logic   w_out_valid;
    entry_t w_in;
    entry_t w_head;

    assign w_empty    = (r_count == '0);
    assign w_in_ready = (r_count != LP_FULL);
    assign w_push     = bus.in_valid && w_in_ready && !flush;
    assign w_rd       = !w_empty && bus.out_ready && !flush;

    assign w_in = '{
        pc:     bus.in_pc,
        inst:   bus.in_inst,
        branch: bus.in_branch,
        baddr:  bus.in_branch_addr,
        adef:   |bus.in_pc[1:0]
    };

`ifdef INST_BUF_BYPASS_EN
    logic w_bypass;
    assign w_bypass    = w_empty && bus.in_valid && !flush;
    assign w_out_valid = !w_empty || w_bypass;
    // An entry taken by decode straight from fetch is never stored.
    assign w_wr        = w_push && !(w_bypass && bus.out_ready);
    assign w_head      = w_bypass ? w_in : r_mem[r_head];
`else
    assign w_out_valid = !w_empty;
    assign w_wr        = w_push;
    assign w_head      = r_mem[r_head];
`endif

    assign bus.in_ready    = w_in_ready;
    assign bus.fetch_stall = !w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.count       = r_count;

    // Head data is forced to zero whenever nothing is valid.
    always_comb begin
        bus.out_pc          = '0;
        bus.out_inst        = '0;
        bus.out_branch      = 1'b0;
        bus.out_branch_addr = '0;
        bus.out_adef        = 1'b0;
        if (w_out_valid) begin
            bus.out_pc          = w_head.pc;
            bus.out_inst        = w_head.inst;
            bus.out_branch      = w_head.branch;
            bus.out_branch_addr = w_head.baddr;
            bus.out_adef        = w_head.adef;
        end
    end

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_rd) begin
                r_head <= r_head + PW'(1);
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + CW'(1);
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_tail] <= w_in;
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed scoreboard bench for inst_buffer (DEPTH=4).
// Expectations come from a queue model updated as stimulus is driven.
module tb_inst_buffer;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        br;
        logic [31:0] ba;
        logic        adef;
    } ent_t;

    logic clk;
    logic rst;
    logic flush;

    inst_buffer_if #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) bus ();

    inst_buffer #(.DEPTH(4), .ADDR_W(32), .INST_W(32)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t q[$];
    int   m_count = 0;
    int   total   = 0;
    int   bad     = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, then advance.
    task automatic cyc();
        ent_t cur;
        ent_t hd;
        logic byp;
        logic exp_ov;
        #4;
        cur = '{pc: bus.in_pc, inst: bus.in_inst, br: bus.in_branch,
                ba: bus.in_branch_addr, adef: |bus.in_pc[1:0]};
        byp = 1'b0;
`ifdef INST_BUF_BYPASS_EN
        byp = (m_count == 0) && bus.in_valid && !flush && !rst;
`endif
        exp_ov = (m_count != 0) || byp;
        if (!rst) begin
            chk("count", 64'(bus.count), 64'(m_count));
            chk("in_ready", 64'(bus.in_ready), 64'(m_count != 4));
            chk("fetch_stall", 64'(bus.fetch_stall), 64'(m_count == 4));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            if (exp_ov) begin
                hd = (m_count != 0) ? q[0] : cur;
                chk("out_pc", 64'(bus.out_pc), 64'(hd.pc));
                chk("out_inst", 64'(bus.out_inst), 64'(hd.inst));
                chk("out_branch", 64'(bus.out_branch), 64'(hd.br));
                chk("out_baddr", 64'(bus.out_branch_addr), 64'(hd.ba));
                chk("out_adef", 64'(bus.out_adef), 64'(hd.adef));
            end else begin
                chk("idle_pc", 64'(bus.out_pc), 64'd0);
                chk("idle_inst", 64'(bus.out_inst), 64'd0);
                chk("idle_baddr", 64'(bus.out_branch_addr), 64'd0);
            end
        end
        if (rst || flush) begin
            q.delete();
        end else begin
            if (m_count != 0 && bus.out_ready) begin
                void'(q.pop_front());
            end
            if (bus.in_valid && m_count != 4 && !(byp && bus.out_ready)) begin
                q.push_back(cur);
            end
        end
        m_count = q.size();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic v, logic [31:0] pc, logic br, logic [31:0] ba,
                       logic ordy, logic fl);
        bus.in_valid       = v;
        bus.in_pc          = pc;
        bus.in_inst        = ~pc ^ 32'h0013_0000;
        bus.in_branch      = br;
        bus.in_branch_addr = ba;
        bus.out_ready      = ordy;
        flush              = fl;
        cyc();
    endtask

    initial begin
        rst                = 1'b1;
        flush              = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_pc          = '0;
        bus.in_inst        = '0;
        bus.in_branch      = 1'b0;
        bus.in_branch_addr = '0;
        bus.out_ready      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_stall", 64'(bus.fetch_stall), 64'd0);
        @(posedge clk);
        #1;

        // fill to DEPTH, then try pushing while full
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h1c00_0000 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0);
        end
        chk("full_count", 64'(bus.count), 64'd4);
        chk("full_stall", 64'(bus.fetch_stall), 64'd1);
        drv(1'b1, 32'h1c00_0010, 1'b0, 32'h0, 1'b0, 1'b0);
        // full with a pop in the same cycle still rejects the push
        drv(1'b1, 32'h1c00_0014, 1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("drained", 64'(bus.count), 64'd0);

        // streaming with wrap
        for (int i = 0; i < 20; i++) begin
            drv(1'b1, 32'h1c00_1000 + 32'(4 * i), 1'b0, 32'h0, 1'b1, 1'b0);
        end
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // branch info
        drv(1'b1, 32'h1c00_0010, 1'b1, 32'h1c00_0100, 1'b0, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // flush with simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h1c00_2000 + 32'(4 * i), 1'b0, 32'h0, 1'b0, 1'b0);
        end
        chk("pre_flush_count", 64'(bus.count), 64'd3);
        drv(1'b1, 32'h1c00_00f0, 1'b1, 32'h1c00_0f00, 1'b1, 1'b1);
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        drv(1'b1, 32'h1c00_0200, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // misaligned PC
        drv(1'b1, 32'h1c00_0002, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b1, 32'h1c00_0004, 1'b0, 32'h0, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // reset in the middle of operation
        drv(1'b1, 32'h1c00_3000, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b1, 32'h1c00_3004, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        drv(1'b1, 32'h1c00_3008, 1'b0, 32'h0, 1'b1, 1'b0);
        rst = 1'b0;
        chk("midrst_count", 64'(bus.count), 64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        drv(1'b1, 32'h1c00_300c, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        drv(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("final_count", 64'(bus.count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
